// File: rtl/mprj_chk_pkg.sv
// mprj_chk_pkg
//   Shared types for the checkpoint monitor: the sequencer state encoding
//   and the failure codes reported on fail_code.
package mprj_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ORDER   = 2'd2;

endpackage

// File: rtl/mprj_chk_stable.sv
// mprj_chk_stable
//   Match-and-stability counter. Counts consecutive cycles with match_i high
//   and flags hit_o on the cycle the run reaches STABLE_CYCLES; the count
//   restarts after a hit so a held value produces one hit per STABLE_CYCLES.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   match_i  comparator result for this cycle
//   clear_i  drop the running count (takes effect next cycle)
//   hit_o    combinational: this cycle completes a stable run
module mprj_chk_stable
    import mprj_chk_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic match_i,
    input  logic clear_i,
    output logic hit_o
);

    // The count only needs to reach STABLE_CYCLES-1; the final matching
    // cycle is recognised combinationally so the owner can register it.
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // hit_o ignores clear_i: the owner decides whether a hit matters, and
    // clear_i only affects the following cycle.
    assign hit_o = match_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || !match_i || hit_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// mprj_checkpoint_monitor
//   Checkpoint sequencer: watches check_bits for an ordered list of up to
//   NUM_STAGES programmed signatures, each of which must hold stable for
//   STABLE_CYCLES cycles. Reports pass, or fail with a code for a per-stage
//   timeout or a signature seen ahead of its turn.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   check_bits                observed check bus
//   cfg_we/cfg_idx/cfg_sig    signature slot write (not while ARMED)
//   cfg_count, cfg_timeout    active stages / per-stage limit, sampled on start
//   start                     arm (or re-arm) pulse
//   busy, pass, fail          status; pass/fail sticky until start or reset
//   fail_code                 FC_NONE / FC_TIMEOUT / FC_ORDER
//   stage_idx, stage_hit      awaited stage, one-cycle acceptance pulse
//   stage_cycles              saturating cycles spent in current stage
module mprj_checkpoint_monitor
    import mprj_chk_pkg::*;
#(
    parameter int CHECK_W       = 16,
    parameter int NUM_STAGES    = 4,
    parameter int TIMEOUT_W     = 24,
    parameter int STABLE_CYCLES = 2,
    localparam int SW           = $clog2(NUM_STAGES)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [CHECK_W-1:0]   check_bits,
    input  logic                 cfg_we,
    input  logic [SW-1:0]        cfg_idx,
    input  logic [CHECK_W-1:0]   cfg_sig,
    input  logic [SW:0]          cfg_count,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 start,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [SW-1:0]        stage_idx,
    output logic                 stage_hit,
    output logic [TIMEOUT_W-1:0] stage_cycles
);

    localparam logic [SW:0]          NUM_ST  = (SW+1)'(NUM_STAGES);
    localparam logic [TIMEOUT_W-1:0] CYC_MAX = '1;

    state_e               state_q;
    logic [CHECK_W-1:0]   sig_q [NUM_STAGES];
    logic [SW:0]          count_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic                 busy_q, pass_q, fail_q, stage_hit_q;
    logic [1:0]           fail_code_q;
    logic [SW-1:0]        stage_idx_q;
    logic [TIMEOUT_W-1:0] stage_cycles_q;

    logic                 cur_match, later_match;
    logic                 cur_hit, later_hit, stab_clr;
    logic                 is_last, cfg_idx_ok, timeout_hit;
    logic [SW:0]          count_clamped;
    logic [TIMEOUT_W-1:0] stage_cycles_d;

    // Current-stage match has priority, so a duplicate signature in a later
    // slot can never be mistaken for an out-of-order arrival.
    assign cur_match = (check_bits == sig_q[stage_idx_q]);

    always_comb begin
        later_match = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (((SW+1)'(j) > {1'b0, stage_idx_q}) && ((SW+1)'(j) < count_q) &&
                (sig_q[j] == check_bits)) begin
                later_match = 1'b1;
            end
        end
        later_match = later_match && !cur_match;
    end

    // Both runs restart on arm, on every acceptance (the awaited stage
    // changes) and whenever the monitor is not armed.
    assign stab_clr = start || (state_q != ST_ARMED) || cur_hit;

    mprj_chk_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_stable_cur (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .match_i (cur_match),
        .clear_i (stab_clr),
        .hit_o   (cur_hit)
    );

    mprj_chk_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_stable_later (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .match_i (later_match),
        .clear_i (stab_clr),
        .hit_o   (later_hit)
    );

    assign cfg_idx_ok    = ({1'b0, cfg_idx} < NUM_ST);
    assign count_clamped = ((cfg_count == '0) || (cfg_count > NUM_ST)) ? NUM_ST : cfg_count;
    assign is_last       = ({1'b0, stage_idx_q} == (count_q - (SW+1)'(1)));

    // The timeout compares against the value the counter is about to take,
    // so a stage lasts exactly cfg_timeout armed cycles.
    assign stage_cycles_d = (stage_cycles_q == CYC_MAX) ? CYC_MAX
                                                        : stage_cycles_q + TIMEOUT_W'(1);
    assign timeout_hit    = (timeout_q != '0) && (stage_cycles_d == timeout_q);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= ST_IDLE;
            count_q        <= NUM_ST;
            timeout_q      <= '0;
            busy_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            fail_code_q    <= FC_NONE;
            stage_idx_q    <= '0;
            stage_hit_q    <= 1'b0;
            stage_cycles_q <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                sig_q[i] <= '0;
            end
        end else begin
            stage_hit_q <= 1'b0;

            if (cfg_we && cfg_idx_ok && (state_q != ST_ARMED)) begin
                sig_q[cfg_idx] <= cfg_sig;
            end

            if (start) begin
                state_q        <= ST_ARMED;
                count_q        <= count_clamped;
                timeout_q      <= cfg_timeout;
                busy_q         <= 1'b1;
                pass_q         <= 1'b0;
                fail_q         <= 1'b0;
                fail_code_q    <= FC_NONE;
                stage_idx_q    <= '0;
                stage_cycles_q <= '0;
            end else if (state_q == ST_ARMED) begin
                if (cur_hit) begin
                    // Acceptance outranks a timeout landing on the same cycle.
                    stage_hit_q    <= 1'b1;
                    stage_cycles_q <= '0;
                    if (is_last) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else begin
                        stage_idx_q <= stage_idx_q + SW'(1);
                    end
                end else if (later_hit) begin
                    state_q        <= ST_FAIL;
                    busy_q         <= 1'b0;
                    fail_q         <= 1'b1;
                    fail_code_q    <= FC_ORDER;
                    stage_cycles_q <= stage_cycles_d;
                end else if (timeout_hit) begin
                    state_q        <= ST_FAIL;
                    busy_q         <= 1'b0;
                    fail_q         <= 1'b1;
                    fail_code_q    <= FC_TIMEOUT;
                    stage_cycles_q <= stage_cycles_d;
                end else begin
                    stage_cycles_q <= stage_cycles_d;
                end
            end
        end
    end

    assign busy         = busy_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign fail_code    = fail_code_q;
    assign stage_idx    = stage_idx_q;
    assign stage_hit    = stage_hit_q;
    assign stage_cycles = stage_cycles_q;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Bench for mprj_checkpoint_monitor: expected stage_hit cycles are queued
// as stimulus is driven and matched by a negedge monitor; status outputs
// are compared inline by each scenario task.
module tb_mprj_checkpoint_monitor;

    localparam int CHECK_W = 16;
    localparam int NS      = 4;
    localparam int TW      = 24;
    localparam int STABLE  = 2;
    localparam int SW      = $clog2(NS);

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [CHECK_W-1:0] check_bits = '0;
    logic            cfg_we = 1'b0;
    logic [SW-1:0]   cfg_idx = '0;
    logic [CHECK_W-1:0] cfg_sig = '0;
    logic [SW:0]     cfg_count = '0;
    logic [TW-1:0]   cfg_timeout = '0;
    logic            start = 1'b0;
    logic            busy, pass, fail, stage_hit;
    logic [1:0]      fail_code;
    logic [SW-1:0]   stage_idx;
    logic [TW-1:0]   stage_cycles;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit mon_en = 1'b0;
    int hitq[$];

    mprj_checkpoint_monitor #(
        .CHECK_W(CHECK_W), .NUM_STAGES(NS), .TIMEOUT_W(TW), .STABLE_CYCLES(STABLE)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .check_bits(check_bits),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sig(cfg_sig),
        .cfg_count(cfg_count), .cfg_timeout(cfg_timeout), .start(start),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .stage_idx(stage_idx), .stage_hit(stage_hit), .stage_cycles(stage_cycles)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Scoreboard: every observed stage_hit must match the oldest queued cycle.
    always @(negedge wb_clk_i) begin
        if (mon_en && stage_hit === 1'b1) begin
            vecs++;
            if (hitq.size() == 0) begin
                errs++;
                $display("FAIL stage_hit_unexpected: got hit at cycle %0d, want none", cyc);
            end else begin
                int e;
                e = hitq.pop_front();
                if (cyc != e) begin
                    errs++;
                    $display("FAIL stage_hit_cycle: got cycle %0d, want cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    task automatic write_sig(input int idx, input logic [CHECK_W-1:0] v);
        cfg_we = 1'b1; cfg_idx = SW'(idx); cfg_sig = v;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns on the negedge of the first armed cycle.
    task automatic arm(input int cnt, input int tmo);
        start = 1'b1; cfg_count = (SW+1)'(cnt); cfg_timeout = TW'(tmo);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        wb_rst_i = 1'b0;
        mon_en = 1'b1;
        tick();
        vecs++; if ({busy, pass, fail, stage_hit} !== 4'b0000) begin errs++;
            $display("FAIL reset_flags: got %b, want 0000", {busy, pass, fail, stage_hit}); end
        vecs++; if (fail_code !== 2'd0 || stage_idx !== '0) begin errs++;
            $display("FAIL reset_code_idx: got %0d/%0d, want 0/0", fail_code, stage_idx); end
        vecs++; if (stage_cycles !== '0) begin errs++;
            $display("FAIL reset_cycles: got %0d, want 0", stage_cycles); end
    endtask

    task automatic test_in_order();
        int t0;
        write_sig(0, 16'hAB60);
        write_sig(1, 16'hAB61);
        check_bits = '0;
        arm(2, 1000);
        t0 = cyc;
        vecs++; if (busy !== 1'b1) begin errs++;
            $display("FAIL busy_rise: got %b, want 1", busy); end
        check_bits = 16'hAB60; hitq.push_back(t0 + STABLE);
        repeat (STABLE) tick();
        vecs++; if (stage_idx !== SW'(1)) begin errs++;
            $display("FAIL inorder_advance: got stage %0d, want 1", stage_idx); end
        repeat (5 - STABLE) tick();
        check_bits = 16'hAB61; hitq.push_back(t0 + 5 + STABLE);
        repeat (STABLE) tick();
        vecs++; if ({pass, fail, busy} !== 3'b100 || fail_code !== 2'd0) begin errs++;
            $display("FAIL inorder_pass: got pass/fail/busy %b code %0d, want 100 code 0",
                     {pass, fail, busy}, fail_code); end
        repeat (3) tick();
        vecs++; if (hitq.size() != 0) begin errs++;
            $display("FAIL inorder_missed_hits: got %0d pending, want 0", hitq.size()); end
    endtask

    task automatic test_out_of_order();
        check_bits = '0;
        arm(2, 1000);
        check_bits = 16'hAB61;
        tick();
        vecs++; if (fail !== 1'b0) begin errs++;
            $display("FAIL order_early: got fail %b, want 0", fail); end
        repeat (STABLE - 1) tick();
        vecs++; if (fail !== 1'b1 || fail_code !== 2'd2 || stage_idx !== '0) begin errs++;
            $display("FAIL order_fail: got fail %b code %0d stage %0d, want 1 2 0",
                     fail, fail_code, stage_idx); end
        check_bits = 16'hAB60;
        repeat (4) tick();
        vecs++; if (fail !== 1'b1 || fail_code !== 2'd2 || pass !== 1'b0) begin errs++;
            $display("FAIL order_sticky: got fail %b code %0d pass %b, want 1 2 0",
                     fail, fail_code, pass); end
    endtask

    task automatic test_timeout();
        int t0;
        check_bits = '0;
        arm(1, 50);
        t0 = cyc;
        repeat (49) tick();
        vecs++; if (fail !== 1'b0 || stage_cycles !== TW'(49)) begin errs++;
            $display("FAIL timeout_pre: got fail %b cycles %0d at +%0d, want 0 49",
                     fail, stage_cycles, cyc - t0); end
        tick();
        vecs++; if (fail !== 1'b1 || fail_code !== 2'd1 || busy !== 1'b0) begin errs++;
            $display("FAIL timeout_fire: got fail %b code %0d busy %b, want 1 1 0",
                     fail, fail_code, busy); end
    endtask

    task automatic test_glitch();
        int t0;
        check_bits = '0;
        arm(1, 0);
        t0 = cyc;
        check_bits = 16'hAB60; tick();
        check_bits = 16'h0000; tick();
        check_bits = 16'hAB60; hitq.push_back(t0 + 2 + STABLE);
        tick();
        vecs++; if (stage_cycles !== TW'(3) || pass !== 1'b0) begin errs++;
            $display("FAIL glitch_no_early: got cycles %0d pass %b, want 3 0", stage_cycles, pass); end
        tick();
        check_bits = '0;
        vecs++; if (pass !== 1'b1) begin errs++;
            $display("FAIL glitch_pass: got pass %b, want 1", pass); end
        repeat (3) tick();
        vecs++; if (hitq.size() != 0) begin errs++;
            $display("FAIL glitch_missed_hits: got %0d pending, want 0", hitq.size()); end
    endtask

    task automatic test_timeout_boundary();
        int t0;
        // Stable run ends exactly on the timeout cycle: acceptance wins.
        check_bits = '0;
        arm(1, 3);
        t0 = cyc;
        tick();
        check_bits = 16'hAB60; hitq.push_back(t0 + 1 + STABLE);
        repeat (STABLE) tick();
        vecs++; if (pass !== 1'b1 || fail !== 1'b0 || fail_code !== 2'd0) begin errs++;
            $display("FAIL boundary_accept: got pass %b fail %b code %0d, want 1 0 0",
                     pass, fail, fail_code); end
        // One cycle later and the timeout gets there first.
        check_bits = '0;
        arm(1, 3);
        repeat (2) tick();
        check_bits = 16'hAB60;
        tick();
        vecs++; if (fail !== 1'b1 || fail_code !== 2'd1 || pass !== 1'b0) begin errs++;
            $display("FAIL boundary_late: got fail %b code %0d pass %b, want 1 1 0",
                     fail, fail_code, pass); end
        check_bits = '0;
        repeat (3) tick();
        vecs++; if (hitq.size() != 0) begin errs++;
            $display("FAIL boundary_missed_hits: got %0d pending, want 0", hitq.size()); end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        check_bits = '0;
        arm(2, 1000);
        t0 = cyc;
        check_bits = 16'hAB60; hitq.push_back(t0 + STABLE);
        // Write while armed must be dropped.
        cfg_we = 1'b1; cfg_idx = '0; cfg_sig = 16'h1234;
        tick();
        cfg_we = 1'b0;
        tick();
        arm(2, 1000);
        t1 = cyc;
        vecs++; if (stage_idx !== '0 || stage_cycles !== '0 || busy !== 1'b1) begin errs++;
            $display("FAIL rearm_state: got stage %0d cycles %0d busy %b, want 0 0 1",
                     stage_idx, stage_cycles, busy); end
        hitq.push_back(t1 + STABLE);
        repeat (STABLE) tick();
        check_bits = 16'hAB61; hitq.push_back(t1 + 2 * STABLE);
        repeat (STABLE) tick();
        vecs++; if (pass !== 1'b1) begin errs++;
            $display("FAIL rearm_pass: got pass %b, want 1", pass); end
        check_bits = '0;
        repeat (3) tick();
        vecs++; if (hitq.size() != 0) begin errs++;
            $display("FAIL rearm_missed_hits: got %0d pending, want 0", hitq.size()); end
    endtask

    task automatic test_mid_reset();
        int t0;
        check_bits = '0;
        arm(2, 1000);
        repeat (3) tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        vecs++; if ({busy, pass, fail} !== 3'b000 || stage_cycles !== '0) begin errs++;
            $display("FAIL midreset_clear: got flags %b cycles %0d, want 000 0",
                     {busy, pass, fail}, stage_cycles); end
        // Count 0 clamps to all four stages; every slot now holds 0000.
        arm(0, 0);
        t0 = cyc;
        for (int k = 1; k <= NS; k++) hitq.push_back(t0 + k * STABLE);
        repeat (NS * STABLE) tick();
        vecs++; if (pass !== 1'b1 || stage_idx !== SW'(NS - 1) || fail !== 1'b0) begin errs++;
            $display("FAIL midreset_zero_slots: got pass %b stage %0d fail %b, want 1 %0d 0",
                     pass, stage_idx, fail, NS - 1); end
        repeat (3) tick();
        vecs++; if (hitq.size() != 0) begin errs++;
            $display("FAIL midreset_missed_hits: got %0d pending, want 0", hitq.size()); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_timeout();
        test_glitch();
        test_timeout_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
